ah_demux_pkt_buf: RTL and testbench
===================================

Name: ah_demux_pkt_buf

Overview:
Parametrised valid/ready 1-to-N demultiplexer: next generation of the combinational AH demux. Adds a registered 2-entry skid buffer on every egress, packet-mode route locking on ing_last, and discard plus counting of beats whose select addresses a non-existent egress. Sits between a single ingress stream and N downstream consumers. No combinational path from any egr_ready to ing_ready.

Parameters:
DATA_W, 34, ingress/egress data width in bits
NUM_EGR, 7, number of egress channels (2..16)
SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_EGR
PKT_MODE, 1, 1 = route locked from first to last beat of a packet; 0 = route chosen per beat
CNT_W, 16, width of drop counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ing_select  in  SEL_W  egress index for current beat, or packet head in PKT_MODE
ing_data  in  DATA_W  ingress payload
ing_last  in  1  last beat of packet; ignored when PKT_MODE=0
ing_valid  in  1  ingress valid
ing_ready  out  1  ingress ready
egr_data  out  NUM_EGR*DATA_W  egress payloads; channel k at bits [k*DATA_W +: DATA_W]
egr_last  out  NUM_EGR  per-egress last
egr_valid  out  NUM_EGR  per-egress valid
egr_ready  in  NUM_EGR  per-egress ready
drop_cnt  out  CNT_W  saturating count of discarded beats
drop_pulse  out  1  one-cycle pulse per discarded beat, registered

Behaviour:
- Ingress transfer: ing_valid & ing_ready in the same cycle. Egress k transfer: egr_valid[k] & egr_ready[k].
- Route:
  - PKT_MODE=0: route = ing_select every beat.
  - PKT_MODE=1: FSM IDLE/LOCKED.
    - IDLE: route = ing_select. Accepted beat with ing_last=0 -> latch route into lock_sel, go to LOCKED. Accepted beat with ing_last=1 (single-beat packet) stays in IDLE.
    - LOCKED: route = lock_sel; ing_select ignored. Accepted beat with ing_last=1 -> IDLE.
- Invalid route (route >= NUM_EGR):
  - ing_ready = 1; beat is accepted and discarded.
  - drop_cnt += 1, saturating at all-ones; drop_pulse = 1 in the following cycle.
  - Packet mode: the whole packet is discarded beat by beat; FSM tracks it normally.
- Valid route k: ing_ready = (buffer k count < 2). count is registered state only.
- Egress buffer, per channel: 2-entry FIFO of {last, data}. egr_valid[k] = (count != 0). egr_data/egr_last come from the head entry.
  - Latency ingress->egress: 1 cycle.
  - Throughput: 1 beat/cycle per egress with egr_ready held high.
  - Simultaneous push and pop on the same buffer: count unchanged, order preserved; legal when full (count=2) only if ing_ready was computed high, so a push never occurs when full.
- Non-selected egresses: unaffected by ingress; keep draining independently.
- ing_select must be stable while ing_valid=1 and ing_ready=0 (IDLE/per-beat mode). The block does not check this.
- Reset (asynchronous, any time including mid-packet):
  - All buffers empty; egr_valid = 0; egr_data = 0; egr_last = 0.
  - FSM = IDLE; lock_sel = 0; drop_cnt = 0; drop_pulse = 0.
  - Partially forwarded packets are lost; the upstream side must reset together with this block.
- No reordering within an egress. Beats to different egresses may complete out of order.

Test Plan:
- PKT_MODE=0, NUM_EGR=7, all egr_ready=1; 8 beats with ing_select=0..6,0 and data=0x100+i -> each appears on the matching egress one cycle later; ing_ready constant 1; drop_cnt=0.
- egr_ready[2]=0; push 3 beats to select 2 -> first two accepted; ing_ready=0 on the third. Raise egr_ready[2] -> 0xA,0xB,0xC drain in order; stalled cycles 0.
- PKT_MODE=1; 4-beat packet head select=5, ing_select toggled to 1 on beats 2-4 -> all 4 beats on egress 5, egr_last only on the 4th; FSM returns to IDLE; next beat with select=1 goes to egress 1.
- ing_select=7 with NUM_EGR=7, 3-beat packet -> all accepted (ing_ready=1), no egr_valid asserted, drop_cnt=3, three drop_pulses.
- CNT_W=2; 5 dropped beats -> drop_cnt saturates at 3.
- rst_n deasserted asynchronously mid-packet, with buffer 3 holding 2 entries -> egr_valid=0 immediately with no clock edge; after release, FSM is IDLE and the next packet is routed by its own head select.

Source files
------------

// File: rtl/ah_demux_pkt_buf.sv
// Valid/ready 1-to-N demux with a 2-entry registered skid buffer per egress,
// optional packet-mode route locking, and discard/counting of beats to missing egresses.
module ah_demux_pkt_buf #(
   parameter int unsigned DATA_W   = 34,
   parameter int unsigned NUM_EGR  = 7,
   parameter int unsigned SEL_W    = 3,
   parameter int unsigned PKT_MODE = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SEL_W-1:0]          ing_select,
   input  logic [DATA_W-1:0]         ing_data,
   input  logic                      ing_last,
   input  logic                      ing_valid,
   output logic                      ing_ready,
   output logic [NUM_EGR*DATA_W-1:0] egr_data,
   output logic [NUM_EGR-1:0]        egr_last,
   output logic [NUM_EGR-1:0]        egr_valid,
   input  logic [NUM_EGR-1:0]        egr_ready,
   output logic [CNT_W-1:0]          drop_cnt,
   output logic                      drop_pulse
);

   localparam int unsigned SEL_N = 1 << SEL_W;
   localparam int unsigned ENT_W = DATA_W + 1;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t             state;
   logic [SEL_W-1:0]   lock_sel;
   logic [SEL_W-1:0]   route_c;
   logic               route_ok_c;
   logic               acc_c;
   logic               drop_c;
   logic [NUM_EGR-1:0] full_c;
   logic [SEL_N-1:0]   full_pad_c;

   // Ready depends only on registered occupancy, never on egr_ready.
   assign route_c    = (PKT_MODE != 0 && state == ST_LOCKED) ? lock_sel : ing_select;
   assign route_ok_c = {1'b0, route_c} < (SEL_W+1)'(NUM_EGR);
   assign full_pad_c = SEL_N'(full_c);
   assign ing_ready  = !route_ok_c || !full_pad_c[route_c];
   assign acc_c      = ing_valid && ing_ready;
   assign drop_c     = acc_c && !route_ok_c;

   // Packet route lock: first beat picks the route, held until the last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         lock_sel <= '0;
      end else if (PKT_MODE != 0 && acc_c) begin
         case (state)
            ST_IDLE: begin
               if (!ing_last) begin
                  state    <= ST_LOCKED;
                  lock_sel <= ing_select;
               end
            end
            ST_LOCKED: begin
               if (ing_last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= drop_c;
         if (drop_c && drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end
   end

   for (genvar k = 0; k < NUM_EGR; k++) begin : g_egr
      logic [1:0]       cnt;
      logic [ENT_W-1:0] slot0;
      logic [ENT_W-1:0] slot1;
      logic             push_c;
      logic             pop_c;

      assign push_c    = acc_c && route_ok_c && (route_c == SEL_W'(k));
      assign pop_c     = (cnt != 2'd0) && egr_ready[k];
      assign full_c[k] = (cnt == 2'd2);

      assign egr_valid[k]                   = (cnt != 2'd0);
      assign egr_data[k*DATA_W +: DATA_W]   = slot0[DATA_W-1:0];
      assign egr_last[k]                    = slot0[DATA_W];

      // slot0 is always the head entry; a pop shifts slot1 forward.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
         end else begin
            case ({push_c, pop_c})
               2'b11: begin
                  if (cnt == 2'd2) begin
                     slot0 <= slot1;
                     slot1 <= {ing_last, ing_data};
                  end else begin
                     slot0 <= {ing_last, ing_data};
                  end
               end
               2'b10: begin
                  if (cnt == 2'd0) slot0 <= {ing_last, ing_data};
                  else             slot1 <= {ing_last, ing_data};
                  cnt <= cnt + 2'd1;
               end
               2'b01: begin
                  slot0 <= slot1;
                  cnt   <= cnt - 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ah_demux_pkt_buf.sv
// Bench for ah_demux_pkt_buf: directed scenarios plus a randomized run checked
// against a queue-per-egress reference model.
module tb_ah_demux_pkt_buf;

   localparam int unsigned DATA_W  = 34;
   localparam int unsigned NUM_EGR = 7;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned CNT0_W  = 2;
   localparam int unsigned RAND_N  = 600;

   logic clk;
   logic rst_n;

   logic [SEL_W-1:0]          ing_select;
   logic [DATA_W-1:0]         ing_data;
   logic                      ing_last;
   logic                      ing_valid;
   logic                      ing_ready;
   logic [NUM_EGR*DATA_W-1:0] egr_data;
   logic [NUM_EGR-1:0]        egr_last;
   logic [NUM_EGR-1:0]        egr_valid;
   logic [NUM_EGR-1:0]        egr_ready;
   logic [CNT_W-1:0]          drop_cnt;
   logic                      drop_pulse;

   logic [SEL_W-1:0]          d0_sel;
   logic [DATA_W-1:0]         d0_data;
   logic                      d0_last;
   logic                      d0_valid;
   logic                      d0_ready;
   logic [NUM_EGR*DATA_W-1:0] d0_egr_data;
   logic [NUM_EGR-1:0]        d0_egr_last;
   logic [NUM_EGR-1:0]        d0_egr_valid;
   logic [NUM_EGR-1:0]        d0_egr_ready;
   logic [CNT0_W-1:0]         d0_drop_cnt;
   logic                      d0_drop_pulse;

   int total;
   int bad;
   logic [CNT_W-1:0] exp_drops;
   logic [DATA_W:0]  mq [NUM_EGR][$];

   ah_demux_pkt_buf #(
      .DATA_W(DATA_W), .NUM_EGR(NUM_EGR), .SEL_W(SEL_W), .PKT_MODE(1), .CNT_W(CNT_W)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ing_select(ing_select), .ing_data(ing_data), .ing_last(ing_last),
      .ing_valid(ing_valid), .ing_ready(ing_ready),
      .egr_data(egr_data), .egr_last(egr_last), .egr_valid(egr_valid), .egr_ready(egr_ready),
      .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
   );

   ah_demux_pkt_buf #(
      .DATA_W(DATA_W), .NUM_EGR(NUM_EGR), .SEL_W(SEL_W), .PKT_MODE(0), .CNT_W(CNT0_W)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .ing_select(d0_sel), .ing_data(d0_data), .ing_last(d0_last),
      .ing_valid(d0_valid), .ing_ready(d0_ready),
      .egr_data(d0_egr_data), .egr_last(d0_egr_last), .egr_valid(d0_egr_valid), .egr_ready(d0_egr_ready),
      .drop_cnt(d0_drop_cnt), .drop_pulse(d0_drop_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      #3;
      total++; if (egr_valid !== '0) begin bad++; $display("FAIL reset_egr_valid got=%0h exp=0", egr_valid); end
      total++; if (egr_data !== '0) begin bad++; $display("FAIL reset_egr_data got=%0h exp=0", egr_data); end
      total++; if (egr_last !== '0) begin bad++; $display("FAIL reset_egr_last got=%0h exp=0", egr_last); end
      total++; if (drop_cnt !== '0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
      total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_drop_pulse got=%0b exp=0", drop_pulse); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (ing_ready !== 1'b1) begin bad++; $display("FAIL reset_ing_ready got=%0b exp=1", ing_ready); end
      total++; if (d0_egr_valid !== '0) begin bad++; $display("FAIL reset_d0_egr_valid got=%0h exp=0", d0_egr_valid); end
   endtask

   task automatic test_back_to_back();
      int e;
      d0_egr_ready = '1;
      d0_last = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i < 8) begin
            d0_valid = 1'b1;
            d0_sel   = SEL_W'(i % 7);
            d0_data  = DATA_W'(32'h100 + i);
         end else begin
            d0_valid = 1'b0;
         end
         #1;
         if (i < 8) begin
            total++; if (d0_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready beat=%0d got=%0b exp=1", i, d0_ready); end
         end
         if (i > 0) begin
            e = (i - 1) % 7;
            total++;
            if (d0_egr_valid !== NUM_EGR'(1 << e)) begin
               bad++; $display("FAIL b2b_valid beat=%0d got=%0h exp=%0h", i-1, d0_egr_valid, NUM_EGR'(1 << e));
            end
            total++;
            if (d0_egr_data[e*DATA_W +: DATA_W] !== DATA_W'(32'h100 + i - 1)) begin
               bad++; $display("FAIL b2b_data beat=%0d got=%0h exp=%0h", i-1, d0_egr_data[e*DATA_W +: DATA_W], 32'h100 + i - 1);
            end
         end
      end
      total++; if (d0_drop_cnt !== '0) begin bad++; $display("FAIL b2b_drop_cnt got=%0d exp=0", d0_drop_cnt); end
   endtask

   task automatic test_saturate();
      int exp_c;
      for (int i = 0; i <= 5; i++) begin
         @(posedge clk); #1;
         if (i < 5) begin
            d0_valid = 1'b1;
            d0_sel   = 3'd7;
            d0_data  = DATA_W'(i);
         end else begin
            d0_valid = 1'b0;
         end
         #1;
         if (i < 5) begin
            total++; if (d0_ready !== 1'b1) begin bad++; $display("FAIL sat_ready beat=%0d got=%0b exp=1", i, d0_ready); end
         end
         if (i > 0) begin
            exp_c = (i < 3) ? i : 3;
            total++; if (d0_drop_cnt !== CNT0_W'(exp_c)) begin bad++; $display("FAIL sat_cnt beat=%0d got=%0d exp=%0d", i-1, d0_drop_cnt, exp_c); end
            total++; if (d0_drop_pulse !== 1'b1) begin bad++; $display("FAIL sat_pulse beat=%0d got=%0b exp=1", i-1, d0_drop_pulse); end
            total++; if (d0_egr_valid !== '0) begin bad++; $display("FAIL sat_egr_valid got=%0h exp=0", d0_egr_valid); end
         end
      end
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] seq [3];
      seq[0] = DATA_W'(32'hA); seq[1] = DATA_W'(32'hB); seq[2] = DATA_W'(32'hC);
      egr_ready  = ~NUM_EGR'(1 << 2);
      ing_last   = 1'b1;
      ing_select = 3'd2;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         ing_valid = 1'b1;
         ing_data  = seq[i];
         #1;
         total++;
         if (ing_ready !== (i < 2)) begin bad++; $display("FAIL stall_ready beat=%0d got=%0b exp=%0b", i, ing_ready, i < 2); end
      end
      @(posedge clk); #1;
      total++; if (ing_ready !== 1'b0) begin bad++; $display("FAIL stall_hold_ready got=%0b exp=0", ing_ready); end
      egr_ready = '1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (egr_valid[2] !== 1'b1) begin bad++; $display("FAIL stall_drain_valid idx=%0d got=0 exp=1", i); end
         total++;
         if (egr_data[2*DATA_W +: DATA_W] !== seq[i]) begin
            bad++; $display("FAIL stall_drain_data idx=%0d got=%0h exp=%0h", i, egr_data[2*DATA_W +: DATA_W], seq[i]);
         end
         if (i == 1) begin
            total++; if (ing_ready !== 1'b1) begin bad++; $display("FAIL stall_resume_ready got=%0b exp=1", ing_ready); end
         end
         @(posedge clk); #1;
         if (i == 1) ing_valid = 1'b0;
      end
      #1;
      total++; if (egr_valid !== '0) begin bad++; $display("FAIL stall_empty got=%0h exp=0", egr_valid); end
   endtask

   task automatic test_pkt_lock();
      int e;
      logic el;
      egr_ready = '1;
      for (int i = 0; i <= 5; i++) begin
         @(posedge clk); #1;
         if (i < 5) begin
            ing_valid  = 1'b1;
            ing_select = (i == 0) ? 3'd5 : 3'd1;
            ing_last   = (i >= 3);
            ing_data   = DATA_W'(32'h200 + i);
         end else begin
            ing_valid = 1'b0;
         end
         #1;
         if (i > 0) begin
            e  = (i - 1 < 4) ? 5 : 1;
            el = (i - 1 >= 3);
            total++;
            if (egr_valid !== NUM_EGR'(1 << e)) begin bad++; $display("FAIL pkt_valid beat=%0d got=%0h exp=%0h", i-1, egr_valid, NUM_EGR'(1 << e)); end
            total++;
            if ({egr_last[e], egr_data[e*DATA_W +: DATA_W]} !== {el, DATA_W'(32'h200 + i - 1)}) begin
               bad++; $display("FAIL pkt_beat beat=%0d got=%0h exp=%0h", i-1, {egr_last[e], egr_data[e*DATA_W +: DATA_W]}, {el, DATA_W'(32'h200 + i - 1)});
            end
         end
      end
   endtask

   task automatic test_drop();
      for (int i = 0; i <= 3; i++) begin
         @(posedge clk); #1;
         if (i < 3) begin
            ing_valid  = 1'b1;
            ing_select = 3'd7;
            ing_last   = (i == 2);
            ing_data   = DATA_W'(32'h300 + i);
         end else begin
            ing_valid = 1'b0;
         end
         #1;
         if (i < 3) begin
            total++; if (ing_ready !== 1'b1) begin bad++; $display("FAIL drop_ready beat=%0d got=%0b exp=1", i, ing_ready); end
         end
         if (i > 0) begin
            total++; if (drop_cnt !== CNT_W'(i)) begin bad++; $display("FAIL drop_cnt beat=%0d got=%0d exp=%0d", i-1, drop_cnt, i); end
            total++; if (drop_pulse !== 1'b1) begin bad++; $display("FAIL drop_pulse beat=%0d got=%0b exp=1", i-1, drop_pulse); end
            total++; if (egr_valid !== '0) begin bad++; $display("FAIL drop_egr_valid got=%0h exp=0", egr_valid); end
         end
      end
      @(posedge clk); #1;
      total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL drop_pulse_end got=%0b exp=0", drop_pulse); end
      exp_drops = CNT_W'(3);
   endtask

   task automatic test_random();
      bit hold, locked, prev_drop, cur_drop, empty, exp_v, exp_rdy;
      int r, lock_r;
      hold = 0; locked = 0; prev_drop = 0; lock_r = 0;
      for (int cyc = 0; cyc < RAND_N + 400; cyc++) begin
         @(posedge clk); #1;
         empty = 1;
         for (int k = 0; k < NUM_EGR; k++) if (mq[k].size() != 0) empty = 0;
         if (cyc >= RAND_N && !locked && !hold && empty) begin
            ing_valid = 1'b0;
            break;
         end
         if (!hold) begin
            if (cyc < RAND_N) begin
               ing_valid  = ($urandom_range(0, 3) != 0);
               ing_select = SEL_W'($urandom_range(0, 7));
               ing_last   = ($urandom_range(0, 2) == 0);
            end else begin
               ing_valid  = locked;
               ing_select = '0;
               ing_last   = 1'b1;
            end
            ing_data = DATA_W'({$urandom(), $urandom()});
         end
         egr_ready = (cyc < RAND_N) ? NUM_EGR'($urandom()) : '1;
         #1;
         r = locked ? lock_r : int'(ing_select);
         if (r >= int'(NUM_EGR)) exp_rdy = 1;
         else                    exp_rdy = (mq[r].size() < 2);
         total++; if (ing_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, ing_ready, exp_rdy); end
         for (int k = 0; k < NUM_EGR; k++) begin
            exp_v = (mq[k].size() != 0);
            total++;
            if (egr_valid[k] !== exp_v) begin
               bad++; $display("FAIL rnd_valid cyc=%0d egr=%0d got=%0b exp=%0b", cyc, k, egr_valid[k], exp_v);
            end else if (exp_v) begin
               total++;
               if ({egr_last[k], egr_data[k*DATA_W +: DATA_W]} !== mq[k][0]) begin
                  bad++; $display("FAIL rnd_beat cyc=%0d egr=%0d got=%0h exp=%0h", cyc, k, {egr_last[k], egr_data[k*DATA_W +: DATA_W]}, mq[k][0]);
               end
               if (egr_ready[k]) void'(mq[k].pop_front());
            end
         end
         total++; if (drop_pulse !== prev_drop) begin bad++; $display("FAIL rnd_pulse cyc=%0d got=%0b exp=%0b", cyc, drop_pulse, prev_drop); end
         total++; if (drop_cnt !== exp_drops) begin bad++; $display("FAIL rnd_drop_cnt cyc=%0d got=%0d exp=%0d", cyc, drop_cnt, exp_drops); end
         cur_drop = 0;
         if (ing_valid && exp_rdy) begin
            if (r >= int'(NUM_EGR)) begin
               cur_drop = 1;
               if (exp_drops != {CNT_W{1'b1}}) exp_drops = exp_drops + CNT_W'(1);
            end else begin
               mq[r].push_back({ing_last, ing_data});
            end
            if (ing_last) locked = 0;
            else if (!locked) begin locked = 1; lock_r = r; end
         end
         hold      = ing_valid && !exp_rdy;
         prev_drop = cur_drop;
      end
      #1;
      total++; if (egr_valid !== '0) begin bad++; $display("FAIL rnd_final_empty got=%0h exp=0", egr_valid); end
      total++; if (locked || hold) begin bad++; $display("FAIL rnd_timeout locked=%0b hold=%0b exp=0", locked, hold); end
   endtask

   task automatic test_async_reset();
      egr_ready  = ~NUM_EGR'(1 << 3);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         ing_valid  = 1'b1;
         ing_select = (i == 0) ? 3'd3 : 3'd0;
         ing_last   = 1'b0;
         ing_data   = DATA_W'(32'h400 + i);
      end
      @(posedge clk); #1;
      ing_valid = 1'b0;
      total++; if (egr_valid !== NUM_EGR'(1 << 3)) begin bad++; $display("FAIL arst_pre_valid got=%0h exp=%0h", egr_valid, NUM_EGR'(1 << 3)); end
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (egr_valid !== '0) begin bad++; $display("FAIL arst_valid got=%0h exp=0", egr_valid); end
      total++; if (egr_data !== '0) begin bad++; $display("FAIL arst_data got=%0h exp=0", egr_data); end
      total++; if (drop_cnt !== '0) begin bad++; $display("FAIL arst_drop_cnt got=%0d exp=0", drop_cnt); end
      @(negedge clk);
      rst_n     = 1'b1;
      egr_ready = '1;
      @(posedge clk); #1;
      ing_valid  = 1'b1;
      ing_select = 3'd4;
      ing_last   = 1'b1;
      ing_data   = DATA_W'(32'h55);
      @(posedge clk); #1;
      ing_valid = 1'b0;
      total++; if (egr_valid !== NUM_EGR'(1 << 4)) begin bad++; $display("FAIL arst_next_valid got=%0h exp=%0h", egr_valid, NUM_EGR'(1 << 4)); end
      total++;
      if ({egr_last[4], egr_data[4*DATA_W +: DATA_W]} !== {1'b1, DATA_W'(32'h55)}) begin
         bad++; $display("FAIL arst_next_beat got=%0h exp=%0h", {egr_last[4], egr_data[4*DATA_W +: DATA_W]}, {1'b1, DATA_W'(32'h55)});
      end
   endtask

   initial begin
      total = 0; bad = 0; exp_drops = '0;
      rst_n = 1'b0;
      ing_select = '0; ing_data = '0; ing_last = 1'b0; ing_valid = 1'b0; egr_ready = '1;
      d0_sel = '0; d0_data = '0; d0_last = 1'b0; d0_valid = 1'b0; d0_egr_ready = '1;
      test_reset();
      test_back_to_back();
      test_saturate();
      test_stall();
      test_pkt_lock();
      test_drop();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
